iomem_polyram: RTL and testbench

IOMEM_POLYRAM -- requirements
Module: iomem_polyram

---
 rtl/iomem_polyram.sv | 90 +++++++++
 tb/tb_iomem_polyram.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iomem_polyram.sv
// iomem_polyram: bus-mapped word RAM plus a fill engine that streams simplerng
// output into a circular RAM range, with a control/status register.
module iomem_polyram #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_2000,
    parameter logic [31:0] CTRL_ADDR = 32'h0300_3000,
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        sel,
    output logic        rng_re,
    input  logic [31:0] rng_do,
    input  logic        rng_wait,
    output logic        busy
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = AW + 1;
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * WORDS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} bus_t;
    typedef enum logic {IDLE_F, FILL} fill_t;

    bus_t bus, bus_n;
    fill_t fill, fill_n;
    logic [31:0] mem [WORDS];
    logic [31:0] ram_q;
    logic [AW-1:0] ptr, idx;
    logic [CW-1:0] remaining, cnt;
    logic ram_hit, ctrl_hit, wr, accept, ctrl_ld, fill_step;

    assign busy = fill == FILL;
    assign iomem_ready = bus == RESP;

    always_comb begin
        ram_hit = iomem_addr >= BASE_ADDR && iomem_addr < END_ADDR;
        ctrl_hit = iomem_addr == CTRL_ADDR;
        sel = iomem_valid && (ram_hit || ctrl_hit);
        wr = |iomem_wstrb;
        idx = AW'((iomem_addr - BASE_ADDR) >> 2);
        cnt = iomem_wdata[16:8] > 9'(WORDS) ? CW'(WORDS) : CW'(iomem_wdata[16:8]);
        // RAM-window requests wait out a fill; the fill owns the RAM port
        accept = resetn && bus == IDLE && sel && !iomem_ready && !(ram_hit && busy);
        ctrl_ld = accept && !ram_hit && wr && !busy;
        fill_step = resetn && fill == FILL && !rng_wait;
        rng_re = fill_step;
        bus_n = bus == RESP ? IDLE : bus == RD_WAIT ? RESP : !accept ? IDLE : ram_hit && !wr ? RD_WAIT : RESP;
        fill_n = ctrl_ld && cnt != '0 ? FILL : fill_step && remaining == CW'(1) ? IDLE_F : fill;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus <= IDLE;
            fill <= IDLE_F;
            ptr <= '0;
            remaining <= '0;
            iomem_rdata <= '0;
        end else begin
            bus <= bus_n;
            fill <= fill_n;
            if (ctrl_ld) begin
                ptr <= iomem_wdata[AW-1:0];
                remaining <= cnt;
            end else if (fill_step) begin
                ptr <= ptr + AW'(1);
                remaining <= remaining - CW'(1);
            end
            if (accept && !ram_hit && !wr)
                iomem_rdata <= {busy, 14'b0, 9'(remaining), 8'(ptr)};
            else if (bus == RD_WAIT)
                iomem_rdata <= ram_q;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (fill_step)
            mem[ptr] <= rng_do;
        else if (accept && ram_hit && wr)
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) mem[idx][8*b +: 8] <= iomem_wdata[8*b +: 8];
        if (accept && ram_hit && !wr)
            ram_q <= mem[idx];
    end
endmodule

// File: tb/tb_iomem_polyram.sv
// tb_iomem_polyram: directed bench with a read-data scoreboard for iomem_polyram.
module tb_iomem_polyram;
    localparam logic [31:0] CTRL = 32'h0300_3000;

    logic        clk = 0;
    logic        resetn = 0;
    logic        iomem_valid = 0;
    logic [3:0]  iomem_wstrb = 0;
    logic [31:0] iomem_addr = 0;
    logic [31:0] iomem_wdata = 0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        sel;
    logic        rng_re;
    logic [31:0] rng_do;
    logic        rng_wait = 0;
    logic        busy;
    logic [31:0] rng_off = 0;
    int unsigned rng_cnt = 0;
    int unsigned busy_tot = 0;
    int unsigned b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    logic [31:0] miss [2] = '{32'h0300_2400, 32'h0300_1FFC};

    iomem_polyram dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata), .sel(sel), .rng_re(rng_re), .rng_do(rng_do),
        .rng_wait(rng_wait), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rng_do = rng_cnt + rng_off;

    always @(posedge clk) begin
        if (rng_re) rng_cnt <= rng_cnt + 1;
        if (busy) busy_tot <= busy_tot + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input string tag, input int exp_lat);
        int lat = 0;
        logic [31:0] e;
        iomem_valid = 1;
        iomem_addr = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        do begin
            tick();
            lat++;
        end while (!iomem_ready && lat < 40);
        chk({tag, " ready"}, 32'(iomem_ready), 1);
        chk({tag, " latency"}, lat, exp_lat);
        if (s == 0 && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " rdata"}, iomem_rdata, e);
        end
        iomem_valid = 0;
        iomem_wstrb = 0;
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag, input int lat);
        sb.push_back(e);
        txn(a, 4'b0000, 0, tag, lat);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst ready", 32'(iomem_ready), 0);
        chk("rst rdata", iomem_rdata, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst rng_re", 32'(rng_re), 0);
        resetn = 1;
        tick();
        rd(CTRL, 32'h0, "status0", 1);

        txn(32'h0300_2010, 4'b1111, 32'hDEAD_BEEF, "w full", 1);
        txn(32'h0300_2010, 4'b0010, 32'h0000_5500, "w byte1", 1);
        rd(32'h0300_2010, 32'hDEAD_55EF, "rmw", 2);
        rd(32'h0300_2013, 32'hDEAD_55EF, "addr lsb", 2);
        txn(32'h0300_23FC, 4'b1111, 32'h1111_1111, "w last", 1);
        rd(32'h0300_23FC, 32'h1111_1111, "r last", 2);
        txn(32'h0300_2000, 4'b1111, 32'h2222_2222, "w first", 1);

        iomem_valid = 1;
        iomem_addr = 32'h0300_23FC;
        #1 chk("sel hit", 32'(sel), 1);
        iomem_valid = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            int seen = 0;
            iomem_valid = 1;
            iomem_addr = miss[i];
            iomem_wstrb = 4'b1111;
            iomem_wdata = 32'hBAD0_BAD0;
            #1 chk("miss sel", 32'(sel), 0);
            repeat (10) begin
                tick();
                if (iomem_ready) seen++;
            end
            chk("miss ready", seen, 0);
            iomem_valid = 0;
            iomem_wstrb = 0;
            tick();
        end
        rd(32'h0300_2000, 32'h2222_2222, "r first", 2);

        rng_off = 1 - rng_cnt;
        b0 = busy_tot;
        txn(CTRL, 4'b1111, 32'h0000_04FE, "ctrl fill4", 1);
        wait_idle("fill4 done");
        chk("fill4 busy cycles", busy_tot - b0, 4);
        rd(CTRL, 32'h0000_0002, "fill4 status", 1);
        rd(32'h0300_23F8, 1, "fill4 w254", 2);
        rd(32'h0300_23FC, 2, "fill4 w255", 2);
        rd(32'h0300_2000, 3, "fill4 w0", 2);
        rd(32'h0300_2004, 4, "fill4 w1", 2);

        rng_off = 32'hA0 - rng_cnt;
        b0 = busy_tot;
        txn(CTRL, 4'b0001, 32'h0000_0310, "ctrl fill3", 1);
        rng_wait = 1;
        #1 chk("wait rng_re", 32'(rng_re), 0);
        tick();
        rng_wait = 0;
        #1 chk("resume rng_re", 32'(rng_re), 1);
        wait_idle("fill3 done");
        chk("fill3 busy cycles", busy_tot - b0, 4);
        rd(32'h0300_2040, 32'hA0, "fill3 w0", 2);
        rd(32'h0300_2044, 32'hA1, "fill3 w1", 2);
        rd(32'h0300_2048, 32'hA2, "fill3 w2", 2);

        rng_off = 32'h100 - rng_cnt;
        txn(CTRL, 4'b1111, 32'h0000_0820, "ctrl fill8", 1);
        txn(CTRL, 4'b1111, 32'h0000_0150, "ctrl busy write", 1);
        rd(CTRL, 32'h8000_0523, "status busy", 1);
        rd(32'h0300_209C, 32'h107, "stalled read", 5);
        chk("fill8 done", 32'(busy), 0);
        rd(CTRL, 32'h0000_0028, "fill8 status", 1);
        rd(32'h0300_2080, 32'h100, "fill8 w0", 2);

        rng_off = 32'h200 - rng_cnt;
        txn(CTRL, 4'b1111, 32'h0000_1060, "ctrl fill16", 1);
        tick();
        resetn = 0;
        tick();
        resetn = 1;
        chk("abort busy", 32'(busy), 0);
        chk("abort rng_re", 32'(rng_re), 0);
        chk("abort ready", 32'(iomem_ready), 0);
        rd(CTRL, 32'h0, "abort status", 1);
        rd(32'h0300_2180, 32'h200, "abort w0", 2);
        rd(32'h0300_2184, 32'h201, "abort w1", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
